// File: rtl/arcade_joy_map.sv
// arcade_joy_map: maps raw HPS joystick words onto per-player arcade control
// bytes {coin,start,jump,fire,up,down,left,right}. Each channel cleans up
// opposing directions, stretches the coin button into a fixed-length pulse
// measured in ce ticks, and can optionally autofire the fire button.
// Optional feature macro: ARCADE_JOY_AUTOFIRE_EN (adds the af_en port and the
// autofire logic; without it fire is a plain registered copy of the source).
module arcade_joy_map #(
   parameter int NUM_PLAYERS = 2,
   parameter int COIN_TICKS  = 4,
   parameter int AF_TICKS    = 3
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     ce,
   input  logic                     merge,
   input  logic [16*NUM_PLAYERS-1:0] joy_in,
`ifdef ARCADE_JOY_AUTOFIRE_EN
   input  logic                     af_en,
`endif
   output logic [8*NUM_PLAYERS-1:0]  joy_out
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_PULSE    = 2'd1;
   localparam logic [1:0] ST_WAIT_REL = 2'd2;

   localparam logic [7:0] COIN_LOAD = 8'(COIN_TICKS);
`ifdef ARCADE_JOY_AUTOFIRE_EN
   localparam logic [7:0] AF_LAST   = 8'(AF_TICKS - 1);
`endif

   logic [15:0] word_or;

   // OR of every player's word, used as the shared source in merge mode
   always_comb begin
      word_or = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         word_or = word_or | joy_in[16*p +: 16];
      end
   end

   for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_chan
      logic [15:0] src;
      logic        unused_hi;
      logic [1:0]  coin_st, coin_st_nx;
      logic [7:0]  coin_cnt, coin_cnt_nx;
      logic        coin_prev;
      logic        fire_nx;
      logic [7:0]  out_nx;
      logic [7:0]  out_q;

      assign src = merge ? word_or : joy_in[16*gp +: 16];

      // Upper byte of the HPS word carries no arcade function here
      assign unused_hi = ^src[15:8];

      // Coin FSM: one fixed-length pulse per press, held coin is ignored
      always_comb begin
         coin_st_nx  = coin_st;
         coin_cnt_nx = coin_cnt;
         case (coin_st)
            ST_IDLE: begin
               if (src[7] && !coin_prev) begin
                  coin_st_nx  = ST_PULSE;
                  coin_cnt_nx = COIN_LOAD;
               end
            end
            ST_PULSE: begin
               if (ce) begin
                  if (coin_cnt <= 8'd1) begin
                     coin_cnt_nx = 8'd0;
                     coin_st_nx  = src[7] ? ST_WAIT_REL : ST_IDLE;
                  end else begin
                     coin_cnt_nx = coin_cnt - 8'd1;
                  end
               end
            end
            ST_WAIT_REL: begin
               if (!src[7]) begin
                  coin_st_nx = ST_IDLE;
               end
            end
            default: begin
               coin_st_nx  = ST_IDLE;
               coin_cnt_nx = 8'd0;
            end
         endcase
      end

`ifdef ARCADE_JOY_AUTOFIRE_EN
      logic       af_ph, af_ph_nx;
      logic [7:0] af_cnt, af_cnt_nx;

      // Autofire phase: high phase first, toggles every AF_TICKS ce ticks
      always_comb begin
         af_ph_nx  = af_ph;
         af_cnt_nx = af_cnt;
         if (!(af_en && src[4])) begin
            af_ph_nx  = 1'b0;
            af_cnt_nx = 8'd0;
         end else if (ce) begin
            if (af_cnt >= AF_LAST) begin
               af_cnt_nx = 8'd0;
               af_ph_nx  = ~af_ph;
            end else begin
               af_cnt_nx = af_cnt + 8'd1;
            end
         end
         fire_nx = (af_en && src[4]) ? ~af_ph_nx : src[4];
      end

      // Autofire phase and tick counter registers
      always_ff @(posedge clk_sys) begin
         if (reset) begin
            af_ph  <= 1'b0;
            af_cnt <= 8'd0;
         end else begin
            af_ph  <= af_ph_nx;
            af_cnt <= af_cnt_nx;
         end
      end
`else
      assign fire_nx = src[4];
`endif

      // Output byte; an opposing direction pair cancels to zero
      assign out_nx = {(coin_st_nx == ST_PULSE),
                       src[6],
                       src[5],
                       fire_nx,
                       src[3] & ~src[2],
                       src[2] & ~src[3],
                       src[1] & ~src[0],
                       src[0] & ~src[1]};

      // Coin state, edge detector and registered output byte
      always_ff @(posedge clk_sys) begin
         if (reset) begin
            coin_st   <= ST_IDLE;
            coin_cnt  <= 8'd0;
            coin_prev <= 1'b0;
            out_q     <= 8'd0;
         end else begin
            coin_st   <= coin_st_nx;
            coin_cnt  <= coin_cnt_nx;
            coin_prev <= src[7];
            out_q     <= out_nx;
         end
      end

      assign joy_out[8*gp +: 8] = out_q;
   end

endmodule

// File: doc/arcade_joy_map.md
ARCADE_JOY_MAP -- requirements
Module: arcade_joy_map

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of player channels (1..4).
REQ-002 Parameter COIN_TICKS, default 4, coin output pulse length in ce ticks (1..255).
REQ-003 Parameter AF_TICKS, default 3, autofire half-period in ce ticks (1..255).
REQ-004 clk_sys  in  1  single clock; all logic rising-edge clk_sys.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ce  in  1  tick enable (one clk_sys cycle wide), timing base for coin and autofire counters.
REQ-007 merge  in  1  1: every output channel driven from OR of all player inputs; 0: channel p from player p only.
REQ-008 joy_in  in  16*NUM_PLAYERS  raw HPS joystick words, player p at bits [16p+15:16p]; bit0 right, 1 left, 2 down, 3 up, 4 fire, 5 jump, 6 start, 7 coin.
REQ-009 joy_out  out  8*NUM_PLAYERS  per player {coin,start,jump,fire,up,down,left,right}, channel p at bits [8p+7:8p].
REQ-010 af_en  in  1  autofire enable for fire bit (present only with ARCADE_JOY_AUTOFIRE_EN).

Function
REQ-011 Source word for channel p SHALL be the OR of all joy_in words when merge=1, else joy_in word p; merge sampled every cycle.
REQ-012 joy_out SHALL be registered; any input change SHALL appear on joy_out exactly one clk_sys cycle later (coin and autofire paths excepted).
REQ-013 Opposing directions: if up and down both set, both outputs SHALL be 0; same for left/right.
REQ-014 start and jump SHALL pass through unmodified (registered).
REQ-015 Each channel SHALL own a coin FSM with states IDLE, PULSE, WAIT_REL.
REQ-016 IDLE -> PULSE on rising edge of source coin bit (previous-cycle sample 0, current 1); counter loaded with COIN_TICKS.
REQ-017 PULSE: coin output 1; counter decrements on each ce; on ce with counter==1 -> WAIT_REL if coin still held, else IDLE.
REQ-018 WAIT_REL: coin output 0; -> IDLE when source coin bit is 0; a held coin SHALL never produce a second pulse.
REQ-019 Coin edges arriving during PULSE or WAIT_REL SHALL be ignored (no queuing).
REQ-020 Coin output SHALL be 0 in IDLE and WAIT_REL.
REQ-021 Toggling merge mid-pulse SHALL NOT abort a PULSE in progress; the FSM continues on the new source word.
REQ-022 Counters SHALL be 8 bits, never wrap below 0 or above COIN_TICKS/AF_TICKS.

Reset
REQ-023 On reset=1 at a clk_sys edge: joy_out=0, all coin FSMs IDLE, counters 0, edge-detect registers 0, autofire phase 0.
REQ-024 Reset SHALL override ce and all inputs in the same cycle; a coin held through reset release SHALL be treated as a rising edge on the first post-reset cycle.
REQ-025 Reset mid-PULSE SHALL drop coin output to 0 on the next cycle.

Configuration
REQ-026 Macro ARCADE_JOY_AUTOFIRE_EN: when defined, af_en port exists; with af_en=1 and fire held, fire output SHALL be 1 for AF_TICKS ce ticks then 0 for AF_TICKS ticks, repeating, starting high on the first cycle after fire asserts; releasing fire or af_en=0 SHALL force fire output to follow source and reset phase/counter.
REQ-027 Without ARCADE_JOY_AUTOFIRE_EN: no af_en port, no autofire logic; fire output is registered source fire.

Verification
REQ-028 NUM_PLAYERS=2, merge=1, joy_in[0]=0x0001, joy_in[1]=0x0008 -> both channels joy_out byte 0x09 one cycle later.
REQ-029 merge=0, player0 word 0x000C (up+down) -> channel0 byte 0x00, channel1 byte 0x00.
REQ-030 COIN_TICKS=4, ce every 8 cycles, player0 coin held 100 cycles -> exactly one coin pulse of 4 ce ticks, then 0 until release; re-press after release gives a second pulse.
REQ-031 Assert reset during PULSE with coin held, release reset -> coin output 0 during reset, new 4-tick pulse starts after release.
REQ-032 AUTOFIRE_EN, AF_TICKS=3, af_en=1, fire held -> fire output 3 ticks high, 3 low, repeating; release fire -> 0 next cycle.
REQ-033 merge toggled 1->0 during player1-initiated pulse on channel0 -> pulse completes full COIN_TICKS length.
